// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared widths and ALU op encodings for the execute stage
package execute_stage_pkg;

    localparam int OP_WIDTH    = 4;
    localparam int SHAMT_WIDTH = 5;

    localparam logic [OP_WIDTH-1:0] ALU_ADD   = 4'd0;
    localparam logic [OP_WIDTH-1:0] ALU_SUB   = 4'd1;
    localparam logic [OP_WIDTH-1:0] ALU_SLL   = 4'd2;
    localparam logic [OP_WIDTH-1:0] ALU_SLT   = 4'd3;
    localparam logic [OP_WIDTH-1:0] ALU_SLTU  = 4'd4;
    localparam logic [OP_WIDTH-1:0] ALU_XOR   = 4'd5;
    localparam logic [OP_WIDTH-1:0] ALU_SRL   = 4'd6;
    localparam logic [OP_WIDTH-1:0] ALU_SRA   = 4'd7;
    localparam logic [OP_WIDTH-1:0] ALU_OR    = 4'd8;
    localparam logic [OP_WIDTH-1:0] ALU_AND   = 4'd9;
    localparam logic [OP_WIDTH-1:0] ALU_PASSB = 4'd10;
    localparam logic [OP_WIDTH-1:0] ALU_MUL   = 4'd11;
    localparam logic [OP_WIDTH-1:0] ALU_MULH  = 4'd12;
    localparam logic [OP_WIDTH-1:0] ALU_MULHU = 4'd13;

endpackage

// File: rtl/execute_stage_alu_comb.sv
// rtl/execute_stage_alu_comb.sv - combinational ALU; multiply codes are legal only with EXE_MUL_EN
import execute_stage_pkg::*;

module execute_stage_alu_comb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  illegal_o
);

    logic [SHAMT_WIDTH-1:0] shamt;

    assign shamt = b_i[SHAMT_WIDTH-1:0];

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_SLL:   result_o = a_i << shamt;
            ALU_SLT:   result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SRL:   result_o = a_i >> shamt;
            ALU_SRA:   result_o = $signed(a_i) >>> shamt;
            ALU_OR:    result_o = a_i | b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_PASSB: result_o = b_i;
            // The product itself lives in the top; here we only decide legality.
            ALU_MUL, ALU_MULH, ALU_MULHU: begin
`ifdef EXE_MUL_EN
                illegal_o = 1'b0;
`else
                illegal_o = 1'b1;
`endif
            end
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - two-stage integer execute unit with flush; EXE_MUL_EN adds MUL/MULH/MULHU
import execute_stage_pkg::*;

module execute_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uop_valid_dec,
    input  logic [OP_WIDTH-1:0]   Alu_Op,
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] Execution_Result,
    output logic                  uop_valid_out,
    output logic                  Illegal_Op
);

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_illegal;
    logic                  accept;

    logic                  s1_valid_q;
    logic                  s1_illegal_q;
    logic [DATA_WIDTH-1:0] s1_result_q;

    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  valid_q;
    logic                  illegal_q;

    execute_stage_alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i      (Alu_Op),
        .a_i       (Operand_A),
        .b_i       (Operand_B),
        .result_o  (alu_result),
        .illegal_o (alu_illegal)
    );

    assign accept = uop_valid_dec & ~flush;

`ifdef EXE_MUL_EN
    logic [2*DATA_WIDTH-1:0] ext_a;
    logic [2*DATA_WIDTH-1:0] ext_b;
    logic [2*DATA_WIDTH-1:0] prod_d;
    logic [2*DATA_WIDTH-1:0] s1_prod_q;
    logic [OP_WIDTH-1:0]     s1_op_q;

    // Sign- or zero-extending to double width lets one multiplier serve both signednesses.
    always_comb begin
        if (Alu_Op == ALU_MULHU) begin
            ext_a = {{DATA_WIDTH{1'b0}}, Operand_A};
            ext_b = {{DATA_WIDTH{1'b0}}, Operand_B};
        end else begin
            ext_a = {{DATA_WIDTH{Operand_A[DATA_WIDTH-1]}}, Operand_A};
            ext_b = {{DATA_WIDTH{Operand_B[DATA_WIDTH-1]}}, Operand_B};
        end
        prod_d = ext_a * ext_b;
    end

    always_comb begin
        case (s1_op_q)
            ALU_MUL:             result_d = s1_prod_q[DATA_WIDTH-1:0];
            ALU_MULH, ALU_MULHU: result_d = s1_prod_q[2*DATA_WIDTH-1:DATA_WIDTH];
            default:             result_d = s1_result_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_prod_q <= '0;
            s1_op_q   <= '0;
        end else if (accept) begin
            s1_prod_q <= prod_d;
            s1_op_q   <= Alu_Op;
        end
    end
`else
    assign result_d = s1_result_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_illegal_q <= 1'b0;
            s1_result_q  <= '0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
            result_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_result_q  <= alu_result;
                s1_illegal_q <= alu_illegal;
            end
            valid_q   <= s1_valid_q & ~flush;
            // Gate with valid so Illegal_Op never shows up on a bubble.
            illegal_q <= s1_valid_q & s1_illegal_q & ~flush;
            result_q  <= result_d;
        end
    end

    assign Execution_Result = result_q;
    assign uop_valid_out    = valid_q;
    assign Illegal_Op       = illegal_q;

endmodule
